// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
//   Sequencing controller for a shift-and-add multiplier datapath in which the
//   multiplicand shifts left, the multiplier shifts right and the accumulator
//   adds the multiplicand whenever the multiplier LSB is 1.
//   One-hot Moore FSM: every output is a decode of the registered state.
//
// Parameters
//   WIDTH  operand width, i.e. number of multiplier bits to iterate
//   CNT_W  iteration counter width (2**CNT_W must exceed WIDTH)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request, sampled only in IDLE
//   q0         current multiplier LSB from the datapath
//   mplr_zero  remaining multiplier is all zeros (early-exit build only)
//   ld_a       load multiplicand register
//   ld_b       load multiplier register
//   clr_acc    clear accumulator
//   add_en     accumulator += multiplicand
//   shift_en   shift multiplicand left / multiplier right by one
//   busy       operation in progress
//   done       one-cycle completion pulse
//   state      one-hot debug vector {DONE,SHIFT,ADD,TEST,LOAD,IDLE}
//   cnt        remaining iterations
//
// Build option
//   MUL_SEQ_CTRL_EARLY_EXIT_EN : when defined, TEST jumps straight to DONE once
//   the remaining multiplier is zero. The accumulator is already aligned in this
//   datapath form, so the skipped iterations would only have added zero.
module mul_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             q0,
  input  logic             mplr_zero,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_acc,
  output logic             add_en,
  output logic             shift_en,
  output logic             busy,
  output logic             done,
  output logic [5:0]       state,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_LOAD  = 6'b000010,
    S_TEST  = 6'b000100,
    S_ADD   = 6'b001000,
    S_SHIFT = 6'b010000,
    S_DONE  = 6'b100000
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

`ifndef MUL_SEQ_CTRL_EARLY_EXIT_EN
  // Port kept so instantiations match both builds; it has no effect here.
  logic mplr_zero_unused;
  assign mplr_zero_unused = mplr_zero;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any vector that is not exactly one of the six one-hot codes falls into the
  // default arm and recovers to IDLE. The counter is cleared whenever the next
  // state is IDLE, which covers recovery and the early-exit path alike.
  always_comb begin
    state_d = S_IDLE;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        state_d = S_TEST;
        cnt_d   = CNT_W'(WIDTH);
      end
      S_TEST: begin
`ifdef MUL_SEQ_CTRL_EARLY_EXIT_EN
        if (mplr_zero)
          state_d = S_DONE;
        else
          state_d = q0 ? S_ADD : S_SHIFT;
`else
        state_d = q0 ? S_ADD : S_SHIFT;
`endif
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // A zero count here cannot occur legally; treating it as the last
        // iteration keeps the counter from wrapping.
        if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q <= CNT_W'(1)) ? S_DONE : S_TEST;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d == S_IDLE)
      cnt_d = '0;
  end

  assign ld_a     = (state_q == S_LOAD);
  assign ld_b     = (state_q == S_LOAD);
  assign clr_acc  = (state_q == S_LOAD);
  assign add_en   = (state_q == S_ADD);
  assign shift_en = (state_q == S_SHIFT);
  assign busy     = (state_q == S_LOAD) || (state_q == S_TEST) ||
                    (state_q == S_ADD)  || (state_q == S_SHIFT);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;
  assign cnt      = cnt_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl
//   Bench for mul_seq_ctrl with WIDTH=8. A shadow multiplier register stands in
//   for the datapath: loaded on ld_b, shifted right on shift_en, and feeding q0
//   and mplr_zero back. Each operation is judged against counts derived from
//   the multiplier value (busy length, adds, shifts, add positions).
module tb_mul_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             q0;
  logic             mplr_zero;
  logic             ld_a;
  logic             ld_b;
  logic             clr_acc;
  logic             add_en;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [5:0]       state;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] mCur;
  logic [WIDTH-1:0] shadow;

  int assertCount;
  int failCount;

  mul_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .mplr_zero(mplr_zero),
    .ld_a(ld_a), .ld_b(ld_b), .clr_acc(clr_acc), .add_en(add_en),
    .shift_en(shift_en), .busy(busy), .done(done), .state(state), .cnt(cnt)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: multiplier register seen by the controller.
  always @(posedge clk) begin
    if (ld_b)
      shadow <= mCur;
    else if (shift_en)
      shadow <= shadow >> 1;
  end
  assign q0        = shadow[0];
  assign mplr_zero = (shadow == '0);

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int popCount(input logic [WIDTH-1:0] m);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(m[i]);
    return n;
  endfunction

  // Number of iterations needed to consume every set bit.
  function automatic int topBit(input logic [WIDTH-1:0] m);
    int t = 0;
    for (int i = 0; i < WIDTH; i++) if (m[i]) t = i + 1;
    return t;
  endfunction

  function automatic int expShifts(input logic [WIDTH-1:0] m);
`ifdef MUL_SEQ_CTRL_EARLY_EXIT_EN
    return topBit(m);
`else
    return WIDTH;
`endif
  endfunction

  // LOAD + (TEST,SHIFT) per iteration + one ADD per set bit; an early exit
  // adds the final TEST that detects the zero multiplier.
  function automatic int expBusy(input logic [WIDTH-1:0] m);
    int s = expShifts(m);
    int b = 1 + 2 * s + popCount(m);
    if (s < WIDTH) b += 1;
    return b;
  endfunction

  // Follows one operation from its LOAD cycle (current negedge) to DONE,
  // and, unless start is being held, confirms the return to IDLE.
  task automatic monitorOp(input logic [WIDTH-1:0] m, input bit midPulse,
                           input bit holdStart);
    int  busyCycles = 0;
    int  adds       = 0;
    int  shifts     = 0;
    bit  seenDone   = 0;
    int  eb         = expBusy(m);
    for (int cyc = 0; cyc < 200 && !seenDone; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (busy) begin
        busyCycles++;
        if (cyc == 0)
          checkOutput("loadStrobes", {27'd0, ld_a, ld_b, clr_acc, add_en, shift_en}, 32'h1C);
        else
          checkOutput("cntRemaining", 32'(cnt), 32'(WIDTH - shifts));
        checkOutput("exclusive",
                    32'(int'(ld_a | ld_b | clr_acc) + int'(add_en) + int'(shift_en) <= 1), 32'd1);
        checkOutput("noDoneWhileBusy", 32'(done), 32'd0);
        if (add_en) begin
          if (shifts < WIDTH)
            checkOutput("addPosition", 32'(m[shifts]), 32'd1);
          else
            checkOutput("addPastEnd", 32'(shifts), 32'(WIDTH - 1));
          adds++;
        end
        if (shift_en) shifts++;
        if (midPulse)
          start = (busyCycles >= 2 && busyCycles + 3 < eb) ? 1'($urandom_range(1, 0)) : 1'b0;
      end else begin
        seenDone = 1;
        checkOutput("donePulse", 32'(done), 32'd1);
        checkOutput("doneState", 32'(state), 32'h20);
        checkOutput("doneStrobes", {27'd0, ld_a, ld_b, clr_acc, add_en, shift_en}, 32'd0);
`ifndef MUL_SEQ_CTRL_EARLY_EXIT_EN
        checkOutput("doneCnt", 32'(cnt), 32'd0);
`endif
      end
    end
    if (midPulse) start = 1'b0;
    checkOutput("reachedDone", 32'(seenDone), 32'd1);
    checkOutput("busyCycles", 32'(busyCycles), 32'(eb));
    checkOutput("addCount", 32'(adds), 32'(popCount(m)));
    checkOutput("shiftCount", 32'(shifts), 32'(expShifts(m)));
    if (!holdStart) begin
      @(negedge clk);
      checkOutput("idleAfterDone", 32'(state), 32'h01);
      checkOutput("doneOneCycle", 32'(done), 32'd0);
      checkOutput("idleCnt", 32'(cnt), 32'd0);
    end
  endtask

  // Launch one operation from IDLE with a single-cycle start pulse.
  task automatic applyStimulus(input logic [WIDTH-1:0] m, input bit midPulse);
    checkOutput("idleBeforeStart", 32'(state), 32'h01);
    mCur  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("enterLoad", 32'(state), 32'h02);
    monitorOp(m, midPulse, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] m2;
    bit               found;
    assertCount = 0;
    failCount   = 0;
    mCur        = 8'h05;
    rst         = 1'b0;
    start       = 1'b1;

    // Reset held with start high: controller must stay idle and quiet.
    repeat (2) @(negedge clk);
    checkOutput("resetState", 32'(state), 32'h01);
    checkOutput("resetCnt", 32'(cnt), 32'd0);
    checkOutput("resetOutputs",
                {25'd0, ld_a, ld_b, clr_acc, add_en, shift_en, busy, done}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("loadAfterReset", 32'(state), 32'h02);
    start = 1'b0;
    monitorOp(8'h05, 1'b0, 1'b0);

    // Directed multipliers, then start noise during an active operation.
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h80, 1'b0);
    applyStimulus(8'hB6, 1'b1);

    // start held high through DONE: one IDLE cycle, then back-to-back LOAD.
    mCur  = 8'h5A;
    start = 1'b1;
    @(negedge clk);
    checkOutput("holdLoad", 32'(state), 32'h02);
    monitorOp(8'h5A, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("holdIdleGap", 32'(state), 32'h01);
    m2   = 8'h33;
    mCur = m2;
    @(negedge clk);
    checkOutput("holdReload", 32'(state), 32'h02);
    start = 1'b0;
    monitorOp(m2, 1'b0, 1'b0);

    // Reset in SHIFT with four iterations left: immediate abort, no done.
    mCur  = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (state == 6'h10 && cnt == CNT_W'(4)) found = 1;
      else @(negedge clk);
    end
    checkOutput("reachShiftCnt4", 32'(found), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abortState", 32'(state), 32'h01);
    checkOutput("abortCnt", 32'(cnt), 32'd0);
    checkOutput("abortBusyDone", {30'd0, busy, done}, 32'd0);
    @(negedge clk);
    checkOutput("abortNoDone", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(8'h3C, 1'b0);

    // Random multipliers with random idle gaps and occasional start noise.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      applyStimulus(8'($urandom), 1'($urandom_range(1, 0)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
